aes_decipher: RTL and testbench

AES_DECIPHER -- requirements
Module: aes_decipher

---
 rtl/aes_pkg.sv | 47 ++++
 rtl/aes_keystream.sv | 35 +++
 rtl/aes_decipher.sv | 136 +++++++++++++
 tb/tb_aes_decipher.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES decipher definitions: inverse S-box table, FSM state type and byte width.
package aes_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StErr
    } state_e;

    localparam logic [BYTE_W-1:0] AES_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_keystream.sv
// Keystream counter: loads the message seed, advances per consumed byte and
// presents the inverse S-box entry at the current index.
module aes_keystream
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] key_i,
    input  logic              advance_i,
    output logic [BYTE_W-1:0] ks_o
);

    logic [BYTE_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = key_i;
        end else if (advance_i) begin
            cnt_d = cnt_q + 8'd1;  // natural 8-bit wrap 0xFF -> 0x00
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ks_o = AES_INV_SBOX[cnt_q];

endmodule

// File: rtl/aes_decipher.sv
// Byte-stream decipher: plaintext = ciphertext XOR inv_sbox[key + i].
// Optional running plaintext checksum port chk when AES_DECIPHER_CHECKSUM_EN is defined.
module aes_decipher
    import aes_pkg::*;
#(
    parameter int unsigned MAX_LEN = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic              new_message,
    input  logic [BYTE_W-1:0] key,
    input  logic [BYTE_W-1:0] data_in,
    output logic              ready_out,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              err
`ifdef AES_DECIPHER_CHECKSUM_EN
    ,
    output logic [BYTE_W-1:0] chk
`endif
);

    localparam logic [BYTE_W-1:0] MaxLen = 8'(MAX_LEN);

    state_e            state_d, state_q;
    logic [BYTE_W-1:0] byte_cnt_d, byte_cnt_q;
    logic [BYTE_W-1:0] data_out_d, data_out_q;
    logic              valid_out_d, valid_out_q;
    logic              err_d, err_q;
    logic [BYTE_W-1:0] ks;
    logic [BYTE_W-1:0] plain;
    logic              key_beat, data_beat, data_ok;

    // Output/decode process: handshake and beat classification.
    always_comb begin
        ready_out = !valid_out_q || ready_in;
        key_beat  = valid_in && ready_out && new_message;
        data_beat = valid_in && ready_out && !new_message;
        data_ok   = data_beat && (state_q == StRun) && (byte_cnt_q < MaxLen);
    end

    // Next-state process.
    always_comb begin
        state_d = state_q;
        if (key_beat) begin
            state_d = StRun;
        end else if (data_beat && !data_ok) begin
            state_d = StErr;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign plain = data_in ^ ks;

    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        err_d       = err_q;
        if (key_beat) begin
            byte_cnt_d = '0;
            err_d      = 1'b0;
        end else if (data_beat && !data_ok) begin
            err_d = 1'b1;
        end
        // A fresh byte replaces a consumed one in the same cycle.
        if (data_ok) begin
            byte_cnt_d  = byte_cnt_q + 8'd1;
            data_out_d  = plain;
            valid_out_d = 1'b1;
        end else if (ready_in) begin
            valid_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_q  <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            err_q       <= err_d;
        end
    end

    aes_keystream u_keystream (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (key_beat),
        .key_i     (key),
        .advance_i (data_ok),
        .ks_o      (ks)
    );

`ifdef AES_DECIPHER_CHECKSUM_EN
    logic [BYTE_W-1:0] chk_d, chk_q;

    always_comb begin
        chk_d = chk_q;
        if (key_beat) begin
            chk_d = '0;
        end else if (data_ok) begin
            chk_d = chk_q ^ plain;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign chk = chk_q;
`endif

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_aes_decipher.sv
// Scoreboard bench for aes_decipher (MAX_LEN=4); driver pushes expected plaintext,
// a negedge monitor pops and compares on each output handshake.
module tb_aes_decipher;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       valid_in = 1'b0;
    logic       new_message = 1'b0;
    logic [7:0] key = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       ready_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in = 1'b1;
    logic       err;
`ifdef AES_DECIPHER_CHECKSUM_EN
    logic [7:0] chk;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    aes_decipher #(.MAX_LEN(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid_in    (valid_in),
        .new_message (new_message),
        .key         (key),
        .data_in     (data_in),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .err         (err)
`ifdef AES_DECIPHER_CHECKSUM_EN
        ,
        .chk         (chk)
`endif
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: compare each output at the negedge preceding its consuming edge.
    always @(negedge clk) begin
        if (reset_n && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %02h expected none", data_out);
            end else begin
                check("data_out", data_out, exp_q.pop_front());
            end
        end
    end

    // Issue one beat aligned at posedge+1; returns posedge+1 after acceptance.
    task automatic beat(input logic nm, input logic [7:0] k, input logic [7:0] d);
        int   n = 0;
        logic acc = 1'b0;
        valid_in = 1'b1;
        new_message = nm;
        key = k;
        data_in = d;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = ready_out;
            @(posedge clk);
            #1;
            n++;
        end
        valid_in = 1'b0;
        new_message = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got not-accepted expected accepted");
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] exp);
        exp_q.push_back(exp);
        beat(1'b0, 8'h00, d);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", 8'(exp_q.size()), 8'd0);
    endtask

    initial begin
        #12;
        check("rst_valid_out", {7'b0, valid_out}, 8'h00);
        check("rst_err", {7'b0, err}, 8'h00);
        check("rst_data_out", data_out, 8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ready_out", {7'b0, ready_out}, 8'h01);

        // Data with no key -> error, no output.
        beat(1'b0, 8'h00, 8'h11);
        check("idle_data_err", {7'b0, err}, 8'h01);
        @(posedge clk);
        #1;
        check("idle_data_no_valid", {7'b0, valid_out}, 8'h00);
        beat(1'b1, 8'h00, 8'h00);
        check("key_clears_err", {7'b0, err}, 8'h00);

        // Key 0x00: index 0 and 1.
        send(8'h52, 8'h00);
        send(8'h09, 8'h00);
        drain();

        // Key 0xFF: wrap 255 -> 0.
        beat(1'b1, 8'hff, 8'h00);
        send(8'h7d, 8'h00);
        send(8'h52, 8'h00);
        drain();

        // Other patterns.
        beat(1'b1, 8'h10, 8'h00);
        send(8'h00, 8'h7c);
        send(8'hff, 8'h1c);
        beat(1'b1, 8'h63, 8'h00);
        send(8'hab, 8'hab);
        send(8'h0f, 8'h83);
        drain();

        // Backpressure: output held 3 cycles while another beat waits.
        beat(1'b1, 8'h20, 8'h00);
        ready_in = 1'b0;
        send(8'h54, 8'h00);
        fork
            send(8'h00, 8'h7b);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_valid_out", {7'b0, valid_out}, 8'h01);
                    check("stall_data_out", data_out, 8'h00);
                    check("stall_ready_out", {7'b0, ready_out}, 8'h00);
                end
                @(posedge clk);
                #1;
                ready_in = 1'b1;
            end
        join
        send(8'h94, 8'h00);
        drain();

        // Length limit: 4 outputs then error.
        beat(1'b1, 8'h00, 8'h00);
        send(8'h52, 8'h00);
        send(8'h09, 8'h00);
        send(8'h6a, 8'h00);
        send(8'hd5, 8'h00);
        beat(1'b0, 8'h00, 8'h30);
        check("maxlen_err", {7'b0, err}, 8'h01);
        drain();
        check("maxlen_no_extra", {7'b0, valid_out}, 8'h00);
        beat(1'b0, 8'h00, 8'h30);
        check("err_sticky", {7'b0, err}, 8'h01);

        // Reset while an output is stalled discards it.
        beat(1'b1, 8'h00, 8'h00);
        ready_in = 1'b0;
        beat(1'b0, 8'h00, 8'h52);
        check("pre_rst_valid", {7'b0, valid_out}, 8'h01);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", {7'b0, valid_out}, 8'h00);
        check("async_rst_data", data_out, 8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ready_in = 1'b1;
        beat(1'b0, 8'h00, 8'h52);
        check("post_rst_err", {7'b0, err}, 8'h01);
        @(posedge clk);
        #1;
        check("post_rst_no_valid", {7'b0, valid_out}, 8'h00);

`ifdef AES_DECIPHER_CHECKSUM_EN
        beat(1'b1, 8'h00, 8'h00);
        check("chk_cleared", chk, 8'h00);
        send(8'h53, 8'h01);
        check("chk_first", chk, 8'h01);
        send(8'h08, 8'h01);
        check("chk_second", chk, 8'h00);
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
